// File: rtl/stopwatch_display.sv
// -----------------------------------------------------------------------------
// stopwatch_display
//   Display end of the stopwatch datapath. A free-running double-dabble
//   converter turns binary minutes/seconds into BCD once every 10 cycles. The
//   result drives a 4-digit time-multiplexed 7-segment display as MM.SS. A
//   pause blinker blanks the display periodically while the core is PAUSED.
//
// Parameters
//   SCAN_DIV    clock cycles each digit stays enabled
//   BLINK_DIV   clock cycles per blink half-period while PAUSED
//   ACTIVE_LOW  1: an/seg/dp are active-low, 0: active-high
//
// Ports
//   clk         system clock, all logic on posedge
//   rst_n       synchronous active-low reset
//   minutes     binary minutes from the stopwatch core
//   seconds     binary seconds from the stopwatch core
//   status      00 IDLE, 01 RUNNING, 10 PAUSED, 11 treated as IDLE
//   an          digit enables, an[3]=minute tens ... an[0]=second ones
//   seg         {g,f,e,d,c,b,a} for the enabled digit
//   dp          decimal point, lit only on digit 2 (MM.SS separator)
//   disp_valid  high once the first conversion has committed
// -----------------------------------------------------------------------------
module stopwatch_display #(
  parameter int unsigned SCAN_DIV   = 4,
  parameter int unsigned BLINK_DIV  = 256,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       disp_valid
);

  localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [6:0]  SEG_DASH      = 7'h40;
  localparam logic [1:0]  STATUS_PAUSED = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  // Converter state. Shift registers hold {bcd, binary}; minutes need a
  // hundreds nibble so that values >= 100 can be detected.
  conv_state_e          state_q, state_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [19:0]          min_sr_q, min_sr_d;
  logic [15:0]          sec_sr_q, sec_sr_d;

  // Committed digits {min tens, min ones, sec tens, sec ones}
  logic [15:0]          dig_q, dig_d;
  logic                 min_dash_q, min_dash_d;
  logic                 valid_q, valid_d;

  // Scan and blink
  logic [SCAN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [1:0]           idx_q, idx_d;
  logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic                 blink_on_q, blink_on_d;

  // Registered pin drivers
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  // Combinational helpers
  logic [19:0]          min_adj;
  logic [15:0]          sec_adj;
  logic [3:0]           nib;
  logic                 show;
  logic [3:0]           an_h;
  logic [6:0]           seg_h;
  logic                 dp_h;

  function automatic logic [3:0] dd_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    min_sr_d    = min_sr_q;
    sec_sr_d    = sec_sr_q;
    dig_d       = dig_q;
    min_dash_d  = min_dash_q;
    valid_d     = valid_q;
    scan_cnt_d  = scan_cnt_q;
    idx_d       = idx_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;

    // Double-dabble: add 3 to every BCD nibble >= 5, then shift left once.
    min_adj = {dd_adj(min_sr_q[19:16]), dd_adj(min_sr_q[15:12]),
               dd_adj(min_sr_q[11:8]), min_sr_q[7:0]};
    sec_adj = {dd_adj(sec_sr_q[15:12]), dd_adj(sec_sr_q[11:8]), sec_sr_q[7:0]};

    case (state_q)
      ST_IDLE: begin
        // Snapshot the inputs; later changes cannot tear this conversion.
        min_sr_d  = {12'd0, minutes};
        sec_sr_d  = {10'd0, seconds};
        bit_cnt_d = 3'd0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        min_sr_d  = min_adj << 1;
        sec_sr_d  = sec_adj << 1;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        dig_d      = {min_sr_q[15:8], sec_sr_q[15:8]};
        min_dash_d = (min_sr_q[19:16] != 4'd0);
        valid_d    = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Digit scan
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end else begin
      scan_cnt_d = scan_cnt_q + 1'b1;
    end

    // Pause blinker; any other status holds the phase ON with a clear counter.
    if (status == STATUS_PAUSED) begin
      if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end else begin
      blink_cnt_d = '0;
      blink_on_d  = 1'b1;
    end

    // Output encode in active-high form, then apply pin polarity.
    case (idx_q)
      2'd0:    nib = dig_q[3:0];
      2'd1:    nib = dig_q[7:4];
      2'd2:    nib = dig_q[11:8];
      default: nib = dig_q[15:12];
    endcase
    show  = valid_q && blink_on_q;
    an_h  = show ? (4'b0001 << idx_q) : 4'b0000;
    seg_h = (idx_q[1] && min_dash_q) ? SEG_DASH : seg_decode(nib);
    if (!show) seg_h = 7'h00;
    dp_h  = show && (idx_q == 2'd2);

    an_d  = an_h  ^ {4{ACTIVE_LOW}};
    seg_d = seg_h ^ {7{ACTIVE_LOW}};
    dp_d  = dp_h  ^ ACTIVE_LOW;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      min_sr_q    <= 20'd0;
      sec_sr_q    <= 16'd0;
      dig_q       <= 16'd0;
      min_dash_q  <= 1'b0;
      valid_q     <= 1'b0;
      scan_cnt_q  <= '0;
      idx_q       <= 2'd0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      an_q        <= {4{ACTIVE_LOW}};
      seg_q       <= {7{ACTIVE_LOW}};
      dp_q        <= ACTIVE_LOW;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      min_sr_q    <= min_sr_d;
      sec_sr_q    <= sec_sr_d;
      dig_q       <= dig_d;
      min_dash_q  <= min_dash_d;
      valid_q     <= valid_d;
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign disp_valid = valid_q;

endmodule

// File: tb/tb_stopwatch_display.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_display
//   Drives two copies of stopwatch_display (active-low and active-high pins)
//   from the same inputs. A cycle model written from the display's behaviour
//   pushes the expected pin state onto a queue at every rising edge; the
//   falling edge pops it and compares both copies. Directed checks cover the
//   reset values, digit codes, dash, blink run lengths and commit latency.
// -----------------------------------------------------------------------------
module tb_stopwatch_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] minutes;
  logic [5:0] seconds;
  logic [1:0] status;

  logic [3:0] an_lo, an_hi;
  logic [6:0] seg_lo, seg_hi;
  logic       dp_lo, dp_hi;
  logic       valid_lo, valid_hi;

  always #5 clk = ~clk;

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b1)) u_dut_lo (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds), .status(status),
    .an(an_lo), .seg(seg_lo), .dp(dp_lo), .disp_valid(valid_lo)
  );

  stopwatch_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV), .ACTIVE_LOW(1'b0)) u_dut_hi (
    .clk(clk), .rst_n(rst_n), .minutes(minutes), .seconds(seconds), .status(status),
    .an(an_hi), .seg(seg_hi), .dp(dp_hi), .disp_valid(valid_hi)
  );

  // Expected pin state in active-high form.
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       valid;
  } frame_t;

  frame_t exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Cycle model state
  int m_e      = 0;   // rising edges since reset release; IDLE at e%10==1
  int m_valid  = 0;
  int m_on     = 1;
  int m_idx    = 0;
  int m_cnt    = 0;
  int m_bcnt   = 0;
  int m_min    = 0;
  int m_sec    = 0;
  int snap_min = 0;
  int snap_sec = 0;

  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [6:0] model_seg(input int idx);
    case (idx)
      0:       return seg_tab[m_sec % 10];
      1:       return seg_tab[m_sec / 10];
      2:       return (m_min >= 100) ? 7'h40 : seg_tab[m_min % 10];
      default: return (m_min >= 100) ? 7'h40 : seg_tab[m_min / 10];
    endcase
  endfunction

  // Advance the model by one rising edge and queue the expected pins.
  task automatic model_step();
    frame_t f;
    logic   on;
    on    = (m_valid != 0) && (m_on != 0);
    f.an  = on ? (4'b0001 << m_idx) : 4'b0000;
    f.seg = on ? model_seg(m_idx) : 7'h00;
    f.dp  = on && (m_idx == 2);
    if (!rst_n) begin
      f.an = 4'b0000; f.seg = 7'h00; f.dp = 1'b0;
      m_e = 0; m_valid = 0; m_on = 1; m_idx = 0; m_cnt = 0; m_bcnt = 0;
      m_min = 0; m_sec = 0;
    end else begin
      m_e++;
      if (m_e % 10 == 1) begin
        snap_min = int'(minutes);
        snap_sec = int'(seconds);
      end
      if (m_e % 10 == 0) begin
        m_min = snap_min; m_sec = snap_sec; m_valid = 1;
      end
      m_cnt++;
      if (m_cnt == SCAN_DIV) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end
      if (status == 2'b10) begin
        m_bcnt++;
        if (m_bcnt == BLINK_DIV) begin
          m_bcnt = 0;
          m_on   = 1 - m_on;
        end
      end else begin
        m_bcnt = 0;
        m_on   = 1;
      end
    end
    f.valid = (m_valid != 0);
    exp_q.push_back(f);
  endtask

  task automatic compare_frame();
    frame_t     f;
    logic [3:0] e_an_lo;
    logic [6:0] e_seg_lo;
    logic       e_dp_lo;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    f        = exp_q.pop_front();
    e_an_lo  = ~f.an;
    e_seg_lo = ~f.seg;
    e_dp_lo  = ~f.dp;
    check($sformatf("e%0d_an_lo", m_e),    32'(an_lo),    32'(e_an_lo));
    check($sformatf("e%0d_seg_lo", m_e),   32'(seg_lo),   32'(e_seg_lo));
    check($sformatf("e%0d_dp_lo", m_e),    32'(dp_lo),    32'(e_dp_lo));
    check($sformatf("e%0d_valid_lo", m_e), 32'(valid_lo), 32'(f.valid));
    check($sformatf("e%0d_an_hi", m_e),    32'(an_hi),    32'(f.an));
    check($sformatf("e%0d_seg_hi", m_e),   32'(seg_hi),   32'(f.seg));
    check($sformatf("e%0d_dp_hi", m_e),    32'(dp_hi),    32'(f.dp));
    check($sformatf("e%0d_valid_hi", m_e), 32'(valid_hi), 32'(f.valid));
  endtask

  // One clock: model at the rising edge, compare at the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_frame();
  endtask

  task automatic wait_an(input logic [3:0] pat, input string tag);
    int n;
    n = 0;
    while (an_lo !== pat && n < 64) begin
      cycle();
      n++;
    end
    check({tag, "_seen"}, 32'(an_lo === pat), 32'd1);
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an_lo"},    32'(an_lo),    32'hF);
    check({tag, "_seg_lo"},   32'(seg_lo),   32'h7F);
    check({tag, "_dp_lo"},    32'(dp_lo),    32'd1);
    check({tag, "_valid_lo"}, 32'(valid_lo), 32'd0);
    check({tag, "_an_hi"},    32'(an_hi),    32'h0);
    check({tag, "_seg_hi"},   32'(seg_hi),   32'h0);
    check({tag, "_dp_hi"},    32'(dp_hi),    32'd0);
    check({tag, "_valid_hi"}, 32'(valid_hi), 32'd0);
  endtask

  initial begin
    int off_len;
    int on_len;
    int n;

    rst_n   = 1'b0;
    minutes = 8'd1;
    seconds = 6'd5;
    status  = 2'b01;

    // Reset held for 3 cycles
    repeat (3) cycle();
    check_reset_pins("t1_reset");

    // 01:05 RUNNING. IDLE in the first cycle after release, so the commit is
    // visible after the 10th rising edge.
    rst_n = 1'b1;
    repeat (9) cycle();
    check("t2_valid_e9", 32'(valid_lo), 32'd0);
    cycle();
    check("t2_valid_e10_lo", 32'(valid_lo), 32'd1);
    check("t2_valid_e10_hi", 32'(valid_hi), 32'd1);
    wait_an(4'b1110, "t2_d0");
    check("t2_d0_seg", 32'(seg_lo), 32'h12);
    check("t2_d0_dp",  32'(dp_lo),  32'd1);
    wait_an(4'b1101, "t2_d1");
    check("t2_d1_seg", 32'(seg_lo), 32'h40);
    wait_an(4'b1011, "t2_d2");
    check("t2_d2_seg",    32'(seg_lo), 32'h79);
    check("t2_d2_dp",     32'(dp_lo),  32'd0);
    check("t2_d2_an_hi",  32'(an_hi),  32'h4);
    check("t2_d2_seg_hi", 32'(seg_hi), 32'h06);
    check("t2_d2_dp_hi",  32'(dp_hi),  32'd1);
    wait_an(4'b0111, "t2_d3");
    check("t2_d3_seg", 32'(seg_lo), 32'h40);

    // Seconds change mid-SHIFT: only 5 or 6 may ever show on seconds ones.
    n = 0;
    while (m_e % 10 != 4 && n < 20) begin
      cycle();
      n++;
    end
    seconds = 6'd6;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (an_lo == 4'b1110)
        check("t3_no_torn", 32'(seg_lo == 7'h12 || seg_lo == 7'h02), 32'd1);
    end
    wait_an(4'b1110, "t3_d0");
    check("t3_d0_seg", 32'(seg_lo), 32'h02);

    // Minutes >= 100 show dashes; 99 shows normally.
    minutes = 8'd120;
    seconds = 6'd59;
    repeat (25) cycle();
    wait_an(4'b0111, "t4_d3");
    check("t4_d3_dash", 32'(seg_lo), 32'h3F);
    wait_an(4'b1011, "t4_d2");
    check("t4_d2_dash", 32'(seg_lo), 32'h3F);
    wait_an(4'b1101, "t4_d1");
    check("t4_d1_seg", 32'(seg_lo), 32'h12);
    wait_an(4'b1110, "t4_d0");
    check("t4_d0_seg", 32'(seg_lo), 32'h10);
    minutes = 8'd99;
    repeat (25) cycle();
    wait_an(4'b0111, "t4b_d3");
    check("t4b_d3_seg", 32'(seg_lo), 32'h10);
    wait_an(4'b1011, "t4b_d2");
    check("t4b_d2_seg", 32'(seg_lo), 32'h10);

    // PAUSED: alternating blank and scan runs of BLINK_DIV cycles each.
    status = 2'b10;
    n = 0;
    while (an_lo !== 4'hF && n < 3 * BLINK_DIV) begin
      cycle();
      n++;
    end
    check("t5_blank_seen", 32'(an_lo === 4'hF), 32'd1);
    off_len = 1;
    for (int k = 0; k < 4 * BLINK_DIV; k++) begin
      cycle();
      if (an_lo == 4'hF) off_len++;
      else break;
    end
    check("t5_off_len", 32'(off_len), 32'(BLINK_DIV));
    on_len = 1;
    for (int k = 0; k < 4 * BLINK_DIV; k++) begin
      cycle();
      if (an_lo != 4'hF) on_len++;
      else break;
    end
    check("t5_on_len", 32'(on_len), 32'(BLINK_DIV));
    // Leave PAUSED while blanked; scan returns within 2 cycles.
    status = 2'b01;
    repeat (2) cycle();
    check("t5_resume", 32'($countones(an_lo)), 32'd3);

    // Reset pulse in the middle of SHIFT
    n = 0;
    while (m_e % 10 != 5 && n < 20) begin
      cycle();
      n++;
    end
    rst_n = 1'b0;
    cycle();
    check_reset_pins("t6_reset");
    rst_n = 1'b1;
    repeat (9) cycle();
    check("t6_valid_e9", 32'(valid_lo), 32'd0);
    cycle();
    check("t6_valid_e10", 32'(valid_lo), 32'd1);
    wait_an(4'b1110, "t6_d0");
    check("t6_d0_seg", 32'(seg_lo), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
